// File: rtl/svnseg_scan_ctrl.sv
// svnseg_scan_ctrl: 4-digit common-anode seven-segment scan controller with blanking gaps and leading-zero suppression
// Ports: clk, rst_n (async active-low); wr_en/wr_addr/wr_data/wr_dp write a digit value and decimal point;
//        lz_en enables leading-zero suppression; dig_n/seg_n/dp_n drive the display (active-low);
//        frame_start pulses in the first driven cycle of digit 0.
module num_to_7seg (
  input  logic [3:0] i_num,
  output logic [6:0] o_seg
);
  always_comb begin
    case (i_num)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      default: o_seg = 7'h0E;
    endcase
  end
endmodule

module svnseg_scan_ctrl #(
  parameter int DIGIT_TICKS = 25000,
  parameter int BLANK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       lz_en,
  output logic [3:0] dig_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_start
);
  localparam int MX = DIGIT_TICKS > BLANK_TICKS ? DIGIT_TICKS : BLANK_TICKS;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] DL = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK_TICKS == 0 ? 0 : BLANK_TICKS - 1);
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_idx;
  logic [3:0][3:0] r_val, r_sh_val;
  logic [3:0]      r_dp, r_sh_dp;
  logic            r_sh_lz;
  logic            w_blank_done, w_drive_done, w_enter, w_first, w_sup, w_src_lz;
  logic [1:0]      w_nidx;
  logic [3:0][3:0] w_src_val;
  logic [3:0]      w_src_dp, w_zero;
  logic [6:0]      w_seg;
  assign w_blank_done = r_state == BLANK && (BLANK_TICKS == 0 || r_cnt == BL);
  assign w_drive_done = r_state == DRIVE && r_cnt == DL;
  // With no gap, a finished digit hands straight over to the next one.
  assign w_enter      = w_blank_done || (w_drive_done && BLANK_TICKS == 0);
  assign w_nidx       = r_state == DRIVE ? r_idx + 2'd1 : r_idx;
  assign w_first      = w_enter && w_nidx == 2'd0;
  // On the shadow-copy edge the outputs must already reflect the values being copied.
  assign w_src_val    = w_first ? r_val : r_sh_val;
  assign w_src_dp     = w_first ? r_dp : r_sh_dp;
  assign w_src_lz     = w_first ? lz_en : r_sh_lz;
  always_comb begin
    w_zero = '0;
    for (int j = 0; j < 4; j++) w_zero[j] = w_src_val[j] == 4'h0 && !w_src_dp[j];
  end
  // Suppressed when every digit from this one upward is a blank zero.
  assign w_sup = w_src_lz && w_nidx != 2'd0 && &(w_zero | ~(4'b1111 << w_nidx));
  num_to_7seg u_dec (.i_num(w_src_val[w_nidx]), .o_seg(w_seg));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= BLANK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_val       <= '0;
      r_dp        <= '0;
      r_sh_val    <= '0;
      r_sh_dp     <= '0;
      r_sh_lz     <= 1'b0;
      dig_n       <= 4'hF;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (wr_en) begin
        r_val[wr_addr] <= wr_data;
        r_dp[wr_addr]  <= wr_dp;
      end
      frame_start <= w_first;
      if (w_first) begin
        r_sh_val <= r_val;
        r_sh_dp  <= r_dp;
        r_sh_lz  <= lz_en;
      end
      if (w_enter) begin
        r_state <= DRIVE;
        r_cnt   <= '0;
        r_idx   <= w_nidx;
        dig_n   <= w_sup ? 4'hF : ~(4'b0001 << w_nidx);
        seg_n   <= w_sup ? 7'h7F : w_seg;
        dp_n    <= w_sup | ~w_src_dp[w_nidx];
      end else if (w_drive_done) begin
        r_state <= BLANK;
        r_cnt   <= '0;
        r_idx   <= r_idx + 2'd1;
        dig_n   <= 4'hF;
        seg_n   <= 7'h7F;
        dp_n    <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_svnseg_scan_ctrl.sv
// tb_svnseg_scan_ctrl: checks the scan controller against a frame-timing reference model
module tb_svnseg_scan_ctrl;
  localparam int D = 4;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic clk = 0, rst_n = 0, wr_en = 0, wr_dp = 0, lz_en = 0;
  logic [1:0] wr_addr = 0;
  logic [3:0] wr_data = 0;
  logic [3:0] a_dig, b_dig;
  logic [6:0] a_seg, b_seg;
  logic a_dp, b_dp, a_fs, b_fs;
  int errs = 0, checks = 0, k = 0;
  logic [3:0] mv [4], sv [4];
  logic md [4], sd [4];
  logic slz;
  always #5 clk = ~clk;
  svnseg_scan_ctrl #(.DIGIT_TICKS(D), .BLANK_TICKS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
    .lz_en(lz_en), .dig_n(a_dig), .seg_n(a_seg), .dp_n(a_dp), .frame_start(a_fs));
  svnseg_scan_ctrl #(.DIGIT_TICKS(D), .BLANK_TICKS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
    .lz_en(1'b0), .dig_n(b_dig), .seg_n(b_seg), .dp_n(b_dp), .frame_start(b_fs));
  // kk = rising edges since reset release; returns the driven digit or -1 when dark
  function automatic int slot_digit(input int b, input int kk);
    int t;
    if (kk == 0) return -1;
    t = kk - (b > 0 ? b : 1);
    if (t < 0 || t % (D + b) >= D) return -1;
    return (t / (D + b)) % 4;
  endfunction
  function automatic logic is_fs(input int b, input int kk);
    int t;
    t = kk - (b > 0 ? b : 1);
    return kk >= 1 && t >= 0 && t % (4 * (D + b)) == 0;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask
  task automatic compare_all();
    int d;
    logic sup;
    d = slot_digit(1, k);
    if (d < 0) begin
      check("a_dig_off", a_dig, 4'hF);
      check("a_seg_off", a_seg, 7'h7F);
      check("a_dp_off", a_dp, 1'b1);
    end else begin
      sup = slz && d != 0;
      for (int j = 0; j < 4; j++) if (j >= d && (sv[j] != 0 || sd[j])) sup = 1'b0;
      check("a_dig", a_dig, sup ? 4'hF : 4'hF ^ (4'd1 << d));
      check("a_seg", a_seg, sup ? 7'h7F : SEG[sv[d]]);
      check("a_dp", a_dp, sup ? 1'b1 : !sd[d]);
    end
    check("a_fs", a_fs, is_fs(1, k));
    d = slot_digit(0, k);
    check("b_dig", b_dig, d < 0 ? 4'hF : 4'hF ^ (4'd1 << d));
    check("b_fs", b_fs, is_fs(0, k));
  endtask
  task automatic step(input logic we, input logic [1:0] a, input logic [3:0] dt, input logic p, input logic lz);
    wr_en = we; wr_addr = a; wr_data = dt; wr_dp = p; lz_en = lz;
    @(posedge clk);
    k++;
    if (is_fs(1, k)) begin
      sv = mv; sd = md; slz = lz;
    end
    if (we) begin
      mv[a] = dt; md[a] = p;
    end
    @(negedge clk);
    wr_en = 0;
    compare_all();
  endtask
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    check("rst_dig", {b_dig, a_dig}, 8'hFF);
    check("rst_seg", a_seg, 7'h7F);
    check("rst_dp_fs", {b_fs, a_fs, a_dp}, 3'b001);
    for (int j = 0; j < 4; j++) begin
      mv[j] = 0; md[j] = 0; sv[j] = 0; sd[j] = 0;
    end
    slz = 0;
    k = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    compare_all();
  endtask
  initial begin
    logic lz;
    int g;
    @(negedge clk);
    do_reset();
    repeat (45) step(0, 0, 0, 0, 0);
    g = 0;
    while (slot_digit(1, k) != 1 && g < 40) begin step(0, 0, 0, 0, 0); g++; end
    check("wait_dig1", slot_digit(1, k), 1);
    step(1, 2, 4'h3, 0, 0);
    repeat (45) step(0, 0, 0, 0, 0);
    step(1, 2, 4'h0, 0, 1);
    step(1, 0, 4'h5, 0, 1);
    repeat (45) step(0, 0, 0, 0, 1);
    step(1, 0, 4'h0, 0, 1);
    repeat (25) step(0, 0, 0, 0, 1);
    step(1, 2, 4'h0, 1, 1);
    repeat (25) step(0, 0, 0, 0, 1);
    step(1, 2, 4'h0, 0, 0);
    step(1, 1, 4'h0, 1, 0);
    repeat (25) step(0, 0, 0, 0, 0);
    g = 0;
    while (!(slot_digit(1, k) == 2 && (k - 1) % (D + 1) == 1) && g < 40) begin step(0, 0, 0, 0, 0); g++; end
    check("wait_dig2", slot_digit(1, k), 2);
    do_reset();
    repeat (45) step(0, 0, 0, 0, 0);
    lz = 1;
    repeat (500) begin
      if ($urandom_range(0, 49) == 0) lz = ~lz;
      step($urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom),
           $urandom_range(0, 3) == 0, lz);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
